// File: rtl/fb_pkg.sv
// Shared types and helpers for the SDRAM framebuffer writer.
//   BASE_DEFAULT : default framebuffer region placed on addr[23:20]
//   fb_state_t   : writer FSM states
//   fb_entry_t   : FIFO payload {start-of-frame flag, RGB565 pixel}
//   rgb565()     : 24-bit RGB888 to 16-bit RGB565 truncation
package fb_pkg;

    localparam logic [3:0]  BASE_DEFAULT = 4'hF;
    localparam int unsigned PIX_W        = 16;
    localparam int unsigned RGB_W        = 24;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fb_state_t;

    typedef struct packed {
        logic             sof;
        logic [PIX_W-1:0] pixel;
    } fb_entry_t;

    // Keep the top bits of each channel: R[7:3], G[7:2], B[7:3].
    function automatic logic [PIX_W-1:0] rgb565(input logic [RGB_W-1:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

endpackage

// File: rtl/fb_fifo.sv
// Synchronous registered FIFO (not fall-through).
//   clk, reset : clock, asynchronous active-high reset
//   push, din  : write side; ignored while full (even with a concurrent pop)
//   pop, dout  : read side; dout shows the head entry while not empty
//   level      : occupancy 0..DEPTH
//   full/empty : registered status flags derived from level
module fb_fifo #(
    parameter int unsigned W     = 17,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_d;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Next occupancy; push+pop together leaves it unchanged.
    always_comb begin
        level_d = level;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level + LW'(1);
            2'b01:   level_d = level - LW'(1);
            default: level_d = level;
        endcase
    end

    // Storage array carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and flags; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_d;
            full  <= (level_d == LW'(DEPTH));
            empty <= (level_d == '0);
        end
    end

endmodule

// File: rtl/fb_writer.sv
// SDRAM framebuffer writer: buffers an RGB888 pixel stream as RGB565 and
// writes it linearly into the framebuffer region through one arbiter port.
//   clk, reset                 : clock, asynchronous active-high reset
//   en                         : allow new SDRAM writes to be issued
//   pix_valid/ready/sof/rgb    : input pixel stream
//   req, rdy                   : arbiter request / completion pulse
//   addr, data, we             : write address {BASE, pixel addr}, RGB565, write
//   frame_done                 : pulse after the last pixel of a frame is written
//   sof_err                    : pulse when SOF arrives at a nonzero expected address
//   level                      : FIFO occupancy
module fb_writer
    import fb_pkg::*;
#(
    parameter int unsigned WIDTH  = 480,
    parameter int unsigned HEIGHT = 272,
    parameter logic [3:0]  BASE   = BASE_DEFAULT,
    parameter int unsigned AN     = 20,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic                     pix_sof,
    input  logic [23:0]              pix_rgb,
    output logic                     req,
    input  logic                     rdy,
    output logic [23:0]              addr,
    output logic [15:0]              data,
    output logic                     we,
    output logic                     frame_done,
    output logic                     sof_err,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned   ENTRY_W  = $bits(fb_entry_t);
    localparam logic [AN-1:0] LAST_PIX = AN'(WIDTH * HEIGHT - 1);

    fb_state_t          state_q;
    fb_state_t          state_d;
    logic [AN-1:0]      addr_q;
    logic [AN-1:0]      addr_d;
    logic [AN-1:0]      exp_q;
    logic [AN-1:0]      exp_d;
    logic [PIX_W-1:0]   data_d;
    logic               req_d;
    logic               frame_done_d;
    logic               sof_err_d;
    logic               pop_c;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_dout;
    fb_entry_t          push_entry;
    fb_entry_t          head;

    assign push_entry = '{sof: pix_sof, pixel: rgb565(pix_rgb)};
    assign head       = fb_entry_t'(fifo_dout);
    assign pix_ready  = ~fifo_full;
    assign addr       = {BASE, addr_q};
    assign we         = 1'b1;

    fb_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pix_valid),
        .pop   (pop_c),
        .din   (push_entry),
        .dout  (fifo_dout),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        req_d        = req;
        addr_d       = addr_q;
        data_d       = data;
        exp_d        = exp_q;
        frame_done_d = 1'b0;
        sof_err_d    = 1'b0;
        pop_c        = 1'b0;
        case (state_q)
            IDLE: begin
                // rdy is ignored here; only a popped pixel starts a request.
                if (en && !fifo_empty) begin
                    pop_c     = 1'b1;
                    addr_d    = head.sof ? '0 : exp_q;
                    data_d    = head.pixel;
                    req_d     = 1'b1;
                    sof_err_d = head.sof && (exp_q != '0);
                    state_d   = REQ;
                end
            end
            REQ: begin
                // Advance the address only once the write has completed.
                if (rdy) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (addr_q == LAST_PIX) begin
                        exp_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        exp_d = addr_q + AN'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req        <= 1'b0;
            addr_q     <= '0;
            exp_q      <= '0;
            data       <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req        <= req_d;
            addr_q     <= addr_d;
            exp_q      <= exp_d;
            data       <= data_d;
            frame_done <= frame_done_d;
            sof_err    <= sof_err_d;
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Scoreboard bench for fb_writer: stimulus pushes expected writes into a
// queue, a negedge monitor pops and compares on each new request.
module tb_fb_writer;

    localparam int unsigned W     = 16;
    localparam int unsigned H     = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AN    = 20;
    localparam logic [3:0]  BASE  = 4'hF;
    localparam int unsigned NPIX  = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic [23:0] pix_rgb;
    logic        req;
    logic        rdy;
    logic [23:0] addr;
    logic [15:0] data;
    logic        we;
    logic        frame_done;
    logic        sof_err;
    logic [4:0]  level;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
        logic        serr;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          model_exp = 0;
    int          fd_count = 0;
    int          serr_count = 0;
    bit          fd_pend = 1'b0;
    bit          req_prev = 1'b0;
    logic [23:0] cur_exp_addr = 24'h0;
    int          rdy_lat = 0;
    bit          arb_on = 1'b0;
    bit          stray_rdy = 1'b0;

    logic [23:0] hv_rgb [5] = '{24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h123456, 24'h808080};
    logic [15:0] hv_565 [5] = '{16'h07E0, 16'h001F, 16'hFFFF, 16'h11AA, 16'h8410};

    fb_writer #(
        .WIDTH  (W),
        .HEIGHT (H),
        .BASE   (BASE),
        .AN     (AN),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_sof    (pix_sof),
        .pix_rgb    (pix_rgb),
        .req        (req),
        .rdy        (rdy),
        .addr       (addr),
        .data       (data),
        .we         (we),
        .frame_done (frame_done),
        .sof_err    (sof_err),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to565(input logic [23:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

    // Reference address model: SOF restarts at 0, wrap after the last pixel.
    function automatic void model_push(input logic sof, input logic [15:0] d565);
        int   a;
        exp_t e;
        a      = sof ? 0 : model_exp;
        e.addr = {BASE, AN'(a)};
        e.data = d565;
        e.serr = sof && (model_exp != 0);
        sb.push_back(e);
        model_exp = (a == int'(NPIX) - 1) ? 0 : a + 1;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_px(input logic [23:0] rgb, input logic sof, input logic [15:0] d565);
        bit acc = 1'b0;
        int t = 0;
        pix_valid = 1'b1;
        pix_rgb   = rgb;
        pix_sof   = sof;
        while (!acc && t < 200) begin
            acc = pix_ready;
            if (acc) model_push(sof, d565);
            @(posedge clk); #1;
            t++;
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        if (!acc) check("push_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int t = 0;
        while (!(sb.size() == 0 && !req && level == 5'd0) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 3000) check("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        model_exp = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Arbiter model: rdy pulse rdy_lat+1 cycles after req rises.
    initial begin
        int cnt = 0;
        rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rdy) rdy = 1'b0;
            else if (stray_rdy) begin
                rdy = 1'b1;
                stray_rdy = 1'b0;
            end else if (req && arb_on) begin
                if (cnt >= rdy_lat) begin
                    rdy = 1'b1;
                    cnt = 0;
                end else cnt++;
            end else cnt = 0;
        end
    end

    // Monitor: compare each new request against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            req_prev = 1'b0;
            fd_pend  = 1'b0;
        end else begin
            if (req && !req_prev) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_req: got addr 0x%0h, expected no request", addr);
                end else begin
                    e = sb.pop_front();
                    check("addr", 32'(addr), 32'(e.addr));
                    check("data", 32'(data), 32'(e.data));
                    check("sof_err", 32'(sof_err), 32'(e.serr));
                    cur_exp_addr = e.addr;
                end
            end else if (sof_err) begin
                check("sof_err_stray", 32'(sof_err), 32'd0);
            end
            if (sof_err) serr_count++;
            if (frame_done || fd_pend) check("frame_done", 32'(frame_done), 32'(fd_pend));
            if (frame_done) fd_count++;
            fd_pend  = req && rdy && (cur_exp_addr == {BASE, AN'(NPIX - 1)});
            req_prev = req;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int accepted;
        bit acc;
        reset     = 1'b1;
        en        = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_rgb   = 24'h0;
        #12;
        // Reset state
        check("rst_req", 32'(req), 32'd0);
        check("rst_addr", 32'(addr), 32'hF00000);
        check("rst_data", 32'(data), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_pix_ready", 32'(pix_ready), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_sof_err", 32'(sof_err), 32'd0);
        check("we", 32'(we), 32'd1);
        @(posedge clk); #1 reset = 1'b0;

        // 1: single SOF pixel, latency and req shape
        en = 1'b1; arb_on = 1'b1; rdy_lat = 2;
        push_px(24'hFF0000, 1'b1, 16'hF800);
        check("t1_req_n1", 32'(req), 32'd0);
        @(posedge clk); #1;
        check("t1_req_n2", 32'(req), 32'd1);
        k = 0;
        while (req && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("t1_req_cycles", 32'(k), 32'd3);
        @(posedge clk); #1;
        check("t1_req_gap", 32'(req), 32'd0);
        drain();

        // 6: stray rdy in IDLE must not advance the address
        stray_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push_px(24'h00FF00, 1'b0, 16'h07E0);
        drain();
        check("t6_frame_done", 32'(fd_count), 32'd0);

        // 2: full frame, frame_done and wrap to 0
        do_reset();
        rdy_lat = 0;
        fd_count = 0;
        for (int i = 0; i < int'(NPIX); i++) begin
            logic [7:0]  b;
            logic [23:0] rgb;
            b   = 8'(i);
            rgb = {b, ~b, b ^ 8'h5A};
            push_px(rgb, i == 0, to565(rgb));
        end
        drain();
        check("t2_frame_done_count", 32'(fd_count), 32'd1);
        push_px(24'h123456, 1'b0, 16'h11AA);
        drain();
        stray_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push_px(24'h808080, 1'b0, 16'h8410);
        drain();
        check("t2_frame_done_after", 32'(fd_count), 32'd1);

        // 3: backpressure with en low, then drain with level tracking
        do_reset();
        en = 1'b0;
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            pix_valid = 1'b1;
            pix_sof   = 1'b0;
            pix_rgb   = hv_rgb[i % 5];
            acc = pix_ready;
            if (acc) begin
                model_push(1'b0, hv_565[i % 5]);
                accepted++;
            end
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        check("t3_accepted", 32'(accepted), 32'd16);
        check("t3_level_full", 32'(level), 32'd16);
        check("t3_pix_ready", 32'(pix_ready), 32'd0);
        en = 1'b1;
        k = 0;
        req_prev_loop: for (int c = 0; c < 500 && k < 16; c++) begin
            bit rp;
            rp = req;
            @(posedge clk); #1;
            if (req && !rp) begin
                k++;
                check("t3_level", 32'(level), 32'(16 - k));
            end
        end
        check("t3_pops", 32'(k), 32'd16);
        drain();

        // 4: mid-frame SOF on the 100th pixel
        do_reset();
        serr_count = 0;
        for (int i = 0; i < 99; i++) begin
            push_px(hv_rgb[i % 5], 1'b0, hv_565[i % 5]);
        end
        push_px(24'hFFFFFF, 1'b1, 16'hFFFF);
        push_px(24'h0000FF, 1'b0, 16'h001F);
        drain();
        check("t4_sof_err_count", 32'(serr_count), 32'd1);

        // 5: reset while a request is outstanding
        do_reset();
        arb_on = 1'b0;
        push_px(24'hFF0000, 1'b1, 16'hF800);
        push_px(24'h00FF00, 1'b0, 16'h07E0);
        push_px(24'h0000FF, 1'b0, 16'h001F);
        k = 0;
        while (!req && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        @(negedge clk); #2;
        check("t5_req_before", 32'(req), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_req_async", 32'(req), 32'd0);
        check("t5_level", 32'(level), 32'd0);
        sb.delete();
        model_exp = 0;
        @(posedge clk); #1;
        reset  = 1'b0;
        arb_on = 1'b1;
        push_px(24'h808080, 1'b1, 16'h8410);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
